// File: rtl/bsg_nonsynth_dramsim3_map_arb_if.sv
// Request bus between the channel ports, the map/arbitrate front end
// and the single DRAMSim3 request port.
interface bsg_nonsynth_dramsim3_map_arb_if #(
    parameter int num_channels_p       = 2,
    parameter int channel_addr_width_p = 16
);
    localparam int lg_num_channels_lp =
        (num_channels_p > 1) ? $clog2(num_channels_p) : 0;
    localparam int addr_width_lp =
        lg_num_channels_lp + channel_addr_width_p;
    localparam int ch_id_width_lp =
        (lg_num_channels_lp > 0) ? lg_num_channels_lp : 1;

    logic [num_channels_p-1:0] v_i;
    logic [num_channels_p-1:0][channel_addr_width_p-1:0] ch_addr_i;
    logic [num_channels_p-1:0] write_i;
    logic [num_channels_p-1:0] ready_o;

    logic                      v_o;
    logic [addr_width_lp-1:0]  addr_o;
    logic                      write_o;
    logic [ch_id_width_lp-1:0] ch_id_o;
    logic                      ready_i;

    modport slave (
        input  v_i, ch_addr_i, write_i, ready_i,
        output ready_o, v_o, addr_o, write_o, ch_id_o
    );

    modport master (
        output v_i, ch_addr_i, write_i, ready_i,
        input  ready_o, v_o, addr_o, write_o, ch_id_o
    );
endinterface

// File: rtl/bsg_nonsynth_dramsim3_map_arb.sv
// Round-robin channel arbiter with DRAMSim3 address mapping and a
// 2-entry non-bypassing output FIFO.
module bsg_nonsynth_dramsim3_map_arb #(
    parameter int channel_addr_width_p = 16,
    parameter int data_width_p         = 64,
    parameter int num_channels_p       = 2,
    parameter int num_columns_p        = 16,
    parameter int num_ba_p             = 4,
    parameter int num_bg_p             = 2,
    parameter int num_ranks_p          = 2,
    parameter int count_width_p        = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic [1:0] mode_i,
    bsg_nonsynth_dramsim3_map_arb_if.slave bus,
    output logic [num_channels_p-1:0][count_width_p-1:0] count_o,
    output logic mode_err_o
);
    localparam int N = num_channels_p;
    localparam int LG = (N > 1) ? $clog2(N) : 0;
    localparam int CHW = (LG > 0) ? LG : 1;
    localparam int AW = LG + channel_addr_width_p;
    localparam int BYTES = data_width_p / 8;
    localparam int OFF = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int COL = $clog2(num_columns_p);
    localparam int BA = $clog2(num_ba_p);
    localparam int BG = $clog2(num_bg_p);
    localparam int RK = $clog2(num_ranks_p);

    logic [CHW-1:0] r_last;
    logic [AW-1:0]  r_addr [2];
    logic           r_write [2];
    logic [CHW-1:0] r_chid [2];
    logic           r_wptr;
    logic           r_rptr;
    logic [1:0]     r_cnt;
    logic [N-1:0][count_width_p-1:0] r_count;
    logic           r_err;

    logic [N-1:0]   w_vrot;
    logic           w_found;
    logic [CHW-1:0] w_grant;
    logic           w_full;
    logic           w_push;
    logic           w_pop;
    logic [AW-1:0]  w_a;
    logic [AW-1:0]  w_ch;
    logic [AW-1:0]  w_map;

    assign w_full = (r_cnt == 2'd2);
    assign w_pop  = bus.v_o & bus.ready_i;
    assign w_push = w_found & ~w_full;

    // Rotate requests so position 0 is the channel after last_grant.
    always_comb begin
        w_vrot = N'({bus.v_i, bus.v_i} >> (int'(r_last) + 1));
    end

    // Pick the first valid channel in rotated order.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_vrot[i]) begin
                w_found = 1'b1;
                w_grant = CHW'((int'(r_last) + 1 + i) % N);
            end
        end
    end

    // Per-channel accept: only the winner, and only with space left.
    always_comb begin
        bus.ready_o = '0;
        if (w_push) begin
            bus.ready_o = N'(1) << w_grant;
        end
    end

    // Map the winner's channel-local address into flat memory space.
    always_comb begin
        w_a   = AW'(bus.ch_addr_i[w_grant]);
        w_ch  = AW'(w_grant);
        w_map = '0;
        unique case (mode_i)
            2'd1: begin
                w_map = ((w_a >> (OFF + COL)) << (OFF + COL + LG))
                      | (w_ch << (OFF + COL))
                      | ((((w_a >> OFF) & ((AW'(1) << COL) - AW'(1))))
                         << OFF);
            end
            2'd2: begin
                w_map = ((((w_a >> OFF) & ((AW'(1) << COL) - AW'(1))))
                         << OFF)
                      | ((((w_a >> (OFF + COL + BA))
                          & ((AW'(1) << BG) - AW'(1))))
                         << (OFF + COL))
                      | ((((w_a >> (OFF + COL))
                          & ((AW'(1) << BA) - AW'(1))))
                         << (OFF + COL + BG))
                      | ((((w_a >> (OFF + COL + BA + BG))
                          & ((AW'(1) << RK) - AW'(1))))
                         << (OFF + COL + BG + BA))
                      | (w_ch << (OFF + COL + BG + BA + RK))
                      | ((w_a >> (OFF + COL + BA + BG + RK))
                         << (OFF + COL + BG + BA + RK + LG));
            end
            default: begin
                w_map = ((w_a >> OFF) << (OFF + LG))
                      | (w_ch << OFF);
            end
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_addr[0]  <= '0;
            r_addr[1]  <= '0;
            r_write[0] <= 1'b0;
            r_write[1] <= 1'b0;
            r_chid[0]  <= '0;
            r_chid[1]  <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            if (w_push) begin
                r_addr[r_wptr]  <= w_map;
                r_write[r_wptr] <= bus.write_i[w_grant];
                r_chid[r_wptr]  <= w_grant;
                r_wptr          <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Round-robin pointer, acceptance counters and sticky mode error.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_last  <= CHW'(N - 1);
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_last <= w_grant;
                if (mode_i == 2'd3) begin
                    r_err <= 1'b1;
                end
            end
            for (int g = 0; g < N; g++) begin
                if (w_push && (w_grant == CHW'(g))) begin
                    r_count[g] <= r_count[g] + count_width_p'(1);
                end
            end
        end
    end

    assign bus.v_o     = (r_cnt != 2'd0);
    assign bus.addr_o  = r_addr[r_rptr];
    assign bus.write_o = r_write[r_rptr];
    assign bus.ch_id_o = r_chid[r_rptr];
    assign count_o     = r_count;
    assign mode_err_o  = r_err;
endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_map_arb.sv
// Directed bench for the DRAMSim3 map/arbiter front end.
// Two instances: 16-bit counters and 2-bit counters (wrap).
module tb_bsg_nonsynth_dramsim3_map_arb;
    logic clk = 1'b0;
    logic reset_n;
    logic [1:0] mode;
    logic [1:0][15:0] count;
    logic mode_err;
    logic [1:0][1:0] count2;
    logic mode_err2;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_nonsynth_dramsim3_map_arb_if #(
        .num_channels_p(2), .channel_addr_width_p(16)
    ) bus ();
    bsg_nonsynth_dramsim3_map_arb_if #(
        .num_channels_p(2), .channel_addr_width_p(16)
    ) bus2 ();

    bsg_nonsynth_dramsim3_map_arb #(
        .channel_addr_width_p(16), .data_width_p(64),
        .num_channels_p(2), .num_columns_p(16), .num_ba_p(4),
        .num_bg_p(2), .num_ranks_p(2), .count_width_p(16)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .mode_i(mode),
        .bus(bus), .count_o(count), .mode_err_o(mode_err)
    );

    bsg_nonsynth_dramsim3_map_arb #(
        .channel_addr_width_p(16), .data_width_p(64),
        .num_channels_p(2), .num_columns_p(16), .num_ba_p(4),
        .num_bg_p(2), .num_ranks_p(2), .count_width_p(2)
    ) dut2 (
        .clk_i(clk), .reset_n_i(reset_n), .mode_i(mode),
        .bus(bus2), .count_o(count2), .mode_err_o(mode_err2)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on one channel, then drain it.
    task automatic send(input string tag, input int ch,
                        input logic [1:0] md, input logic [15:0] a,
                        input logic [16:0] exp_addr);
        mode = md;
        bus.ch_addr_i[ch] = a;
        bus.write_i = 2'b00;
        bus.write_i[ch] = 1'b1;
        bus.v_i = 2'b00;
        bus.v_i[ch] = 1'b1;
        bus.ready_i = 1'b0;
        #1;
        chk({tag, "_ready"}, 64'(bus.ready_o), 64'(bus.v_i));
        chk({tag, "_vo_pre"}, 64'(bus.v_o), 64'd0);
        tick();
        bus.v_i = 2'b00;
        mode = 2'd0;
        #1;
        chk({tag, "_vo"}, 64'(bus.v_o), 64'd1);
        chk({tag, "_addr"}, 64'(bus.addr_o), 64'(exp_addr));
        chk({tag, "_chid"}, 64'(bus.ch_id_o), 64'(ch));
        chk({tag, "_wr"}, 64'(bus.write_o), 64'd1);
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        #1;
        chk({tag, "_drained"}, 64'(bus.v_o), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        mode = 2'd0;
        bus.v_i = '0;
        bus.ch_addr_i = '0;
        bus.write_i = '0;
        bus.ready_i = 1'b0;
        bus2.v_i = '0;
        bus2.ch_addr_i = '0;
        bus2.write_i = '0;
        bus2.ready_i = 1'b0;
        #1;
        chk("rst_vo", 64'(bus.v_o), 64'd0);
        chk("rst_addr", 64'(bus.addr_o), 64'd0);
        chk("rst_wr", 64'(bus.write_o), 64'd0);
        chk("rst_chid", 64'(bus.ch_id_o), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_err", 64'(mode_err), 64'd0);
        chk("rst_ready", 64'(bus.ready_o), 64'd0);
        #6;
        reset_n = 1'b1;
        tick();

        // Round robin with both channels valid, ready_i high.
        bus.ch_addr_i[0] = 16'h0008;
        bus.ch_addr_i[1] = 16'h0010;
        bus.v_i = 2'b11;
        bus.ready_i = 1'b1;
        #1;
        chk("rr0_ready", 64'(bus.ready_o), 64'b01);
        tick();
        chk("rr1_ready", 64'(bus.ready_o), 64'b10);
        chk("rr1_chid", 64'(bus.ch_id_o), 64'd0);
        chk("rr1_addr", 64'(bus.addr_o), 64'h10);
        tick();
        chk("rr2_ready", 64'(bus.ready_o), 64'b01);
        chk("rr2_chid", 64'(bus.ch_id_o), 64'd1);
        chk("rr2_addr", 64'(bus.addr_o), 64'h28);
        tick();
        chk("rr3_ready", 64'(bus.ready_o), 64'b10);
        chk("rr3_chid", 64'(bus.ch_id_o), 64'd0);
        tick();
        chk("rr4_ready", 64'(bus.ready_o), 64'b01);
        chk("rr4_chid", 64'(bus.ch_id_o), 64'd1);
        tick();
        chk("rr5_ready", 64'(bus.ready_o), 64'b10);
        chk("rr5_chid", 64'(bus.ch_id_o), 64'd0);
        tick();
        bus.v_i = 2'b00;
        #1;
        chk("rr_count", 64'(count), 64'h0003_0003);
        chk("rr_last_chid", 64'(bus.ch_id_o), 64'd1);
        tick();
        bus.ready_i = 1'b0;
        #1;
        chk("rr_empty", 64'(bus.v_o), 64'd0);

        // Mapping modes; mode_i changes after acceptance.
        send("m0", 1, 2'd0, 16'h1238, 17'h02478);
        send("m1", 1, 2'd1, 16'h1238, 17'h024B8);
        send("m2", 1, 2'd2, 16'h1238, 17'h028B8);
        chk("err_before_m3", 64'(mode_err), 64'd0);
        send("m3", 0, 2'd3, 16'h1238, 17'h02470);
        chk("err_after_m3", 64'(mode_err), 64'd1);

        // Fill, full stall, FIFO-order drain, no bypass.
        bus.write_i = 2'b00;
        bus.v_i = 2'b11;
        bus.ready_i = 1'b0;
        #1;
        chk("fA_ready", 64'(bus.ready_o), 64'b10);
        tick();
        chk("fB_ready", 64'(bus.ready_o), 64'b01);
        tick();
        bus.ready_i = 1'b1;
        #1;
        chk("fC_ready_full", 64'(bus.ready_o), 64'b00);
        chk("fC_vo", 64'(bus.v_o), 64'd1);
        chk("fC_chid", 64'(bus.ch_id_o), 64'd1);
        tick();
        chk("fD_ready", 64'(bus.ready_o), 64'b10);
        chk("fD_chid", 64'(bus.ch_id_o), 64'd0);
        tick();
        bus.v_i = 2'b00;
        #1;
        chk("fE_vo", 64'(bus.v_o), 64'd1);
        chk("fE_chid", 64'(bus.ch_id_o), 64'd1);
        tick();
        chk("fF_empty", 64'(bus.v_o), 64'd0);
        bus.ready_i = 1'b0;
        bus.v_i = 2'b01;
        #1;
        chk("fF_ready", 64'(bus.ready_o), 64'b01);
        tick();
        chk("fG_ready", 64'(bus.ready_o), 64'b01);
        tick();
        bus.v_i = 2'b00;
        #1;
        chk("fH_vo", 64'(bus.v_o), 64'd1);
        chk("fH_count", 64'(count), 64'h0008_0007);
        chk("fH_err_sticky", 64'(mode_err), 64'd1);

        // Asynchronous reset with two entries buffered.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_vo", 64'(bus.v_o), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_err", 64'(mode_err), 64'd0);
        chk("arst_addr", 64'(bus.addr_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // 2-bit counter wraps: five accepts on channel 0.
        bus2.v_i = 2'b01;
        bus2.ready_i = 1'b1;
        #1;
        chk("w_ready0", 64'(bus2.ready_o), 64'b01);
        tick();
        tick();
        tick();
        chk("w_ready3", 64'(bus2.ready_o), 64'b01);
        tick();
        tick();
        bus2.v_i = 2'b00;
        #1;
        chk("w_count", 64'(count2), 64'b0001);
        chk("w_err", 64'(mode_err2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
